// File: rtl/ioctl_pkg.sv
// ioctl_pkg: state encoding and shared constants for the ioctl host transfer engine
package ioctl_pkg;
    localparam int ADDR_W_DEF = 25;
    localparam int PACE_W = 8;
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_NVRAM = 8'd4;
    typedef enum logic [3:0] {
        IDLE, DL_OPEN, DL_FETCH, DL_WRITE, DL_GAP, UL_OPEN, UL_SETTLE, UL_OUT, CLOSE
    } state_t;
endpackage

// File: rtl/ioctl_pace_cnt.sv
// ioctl_pace_cnt: loadable down-counter that freezes while hold is high
module ioctl_pace_cnt
    import ioctl_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              load,
    input  logic [PACE_W-1:0] load_val,
    input  logic              hold,
    output logic              zero
);
    logic [PACE_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (hold || cnt_q == '0) ? cnt_q : cnt_q - PACE_W'(1);
    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/ioctl_host_xfer.sv
// ioctl_host_xfer: host-side ioctl loader that streams bytes into or out of the core
module ioctl_host_xfer
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WR_GAP = 3,
    parameter int RD_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_upload,
    input  logic [7:0]        cmd_index,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              snk_valid,
    output logic [7:0]        snk_data,
    input  logic              snk_ready,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_din,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);
    localparam logic [PACE_W-1:0] GAP_LD = PACE_W'(WR_GAP > 1 ? WR_GAP - 2 : 0);
    localparam logic [PACE_W-1:0] LAT_LD = PACE_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d, cnt_q, cnt_d, addr_q, addr_d;
    logic [7:0] index_q, index_d, dout_q, dout_d, snk_data_q, snk_data_d;
    logic dl_q, dl_d, ul_q, ul_d, wr_q, wr_d, snk_valid_q, snk_valid_d;
    logic busy_q, busy_d, done_q, done_d;
    logic pace_load, pace_zero, last;
    logic [PACE_W-1:0] pace_val;

    ioctl_pace_cnt u_pace (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (pace_load),
        .load_val(pace_val),
        .hold    (ioctl_wait),
        .zero    (pace_zero)
    );

    assign src_ready = state_q == DL_FETCH && src_valid && !ioctl_wait;
    assign last = (cnt_q + ONE) == len_q;

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        index_d = index_q;
        dout_d = dout_q;
        snk_data_d = snk_data_q;
        snk_valid_d = snk_valid_q;
        dl_d = dl_q;
        ul_d = ul_q;
        wr_d = 1'b0;
        busy_d = busy_q;
        done_d = 1'b0;
        pace_load = 1'b0;
        pace_val = GAP_LD;
        case (state_q)
            IDLE: if (cmd_start) begin
                busy_d = 1'b1;
                addr_d = '0;
                cnt_d = '0;
                index_d = cmd_index;
                len_d = cmd_len;
                done_d = cmd_len == '0;
                state_d = (cmd_len == '0) ? CLOSE : (cmd_upload ? UL_OPEN : DL_OPEN);
            end
            DL_OPEN: begin
                dl_d = 1'b1;
                state_d = DL_FETCH;
            end
            DL_FETCH: if (src_ready) begin
                dout_d = src_data;
                wr_d = 1'b1;
                state_d = DL_WRITE;
            end
            DL_WRITE: begin
                cnt_d = cnt_q + ONE;
                if (last) begin
                    dl_d = 1'b0;
                    done_d = 1'b1;
                    state_d = CLOSE;
                end else begin
                    addr_d = addr_q + ONE;
                    pace_load = 1'b1;
                    state_d = (WR_GAP > 1) ? DL_GAP : DL_FETCH;
                end
            end
            DL_GAP: if (pace_zero && !ioctl_wait) state_d = DL_FETCH;
            UL_OPEN: begin
                ul_d = 1'b1;
                pace_load = 1'b1;
                pace_val = LAT_LD;
                state_d = UL_SETTLE;
            end
            UL_SETTLE: if (pace_zero && !ioctl_wait) begin
                snk_data_d = ioctl_din;
                snk_valid_d = 1'b1;
                state_d = UL_OUT;
            end
            UL_OUT: if (snk_ready) begin
                snk_valid_d = 1'b0;
                cnt_d = cnt_q + ONE;
                if (last) begin
                    ul_d = 1'b0;
                    done_d = 1'b1;
                    state_d = CLOSE;
                end else begin
                    addr_d = addr_q + ONE;
                    pace_load = 1'b1;
                    pace_val = LAT_LD;
                    state_d = UL_SETTLE;
                end
            end
            CLOSE: begin
                busy_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            len_q <= '0;
            cnt_q <= '0;
            addr_q <= '0;
            index_q <= '0;
            dout_q <= '0;
            snk_data_q <= '0;
            snk_valid_q <= 1'b0;
            dl_q <= 1'b0;
            ul_q <= 1'b0;
            wr_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            index_q <= index_d;
            dout_q <= dout_d;
            snk_data_q <= snk_data_d;
            snk_valid_q <= snk_valid_d;
            dl_q <= dl_d;
            ul_q <= ul_d;
            wr_q <= wr_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end

    assign snk_valid = snk_valid_q;
    assign snk_data = snk_data_q;
    assign ioctl_download = dl_q;
    assign ioctl_upload = ul_q;
    assign ioctl_index = index_q;
    assign ioctl_wr = wr_q;
    assign ioctl_addr = addr_q;
    assign ioctl_dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_ioctl_host_xfer.sv
// tb_ioctl_host_xfer: directed checks of download, upload, zero length, reset and ignored starts
module tb_ioctl_host_xfer;
    import ioctl_pkg::*;
    localparam int AW = 25;
    logic clk_sys = 1'b0, reset_n = 1'b0;
    logic cmd_start = 1'b0, cmd_upload = 1'b0;
    logic [7:0] cmd_index = '0;
    logic [AW-1:0] cmd_len = '0;
    logic src_valid = 1'b0, src_ready, snk_valid, snk_ready, ioctl_wait = 1'b0;
    logic [7:0] src_data, snk_data, ioctl_index, ioctl_dout, ioctl_din = '0;
    logic ioctl_download, ioctl_upload, ioctl_wr, busy, done;
    logic [AW-1:0] ioctl_addr;
    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] src_mem [8];
    int src_idx = 0, src_base = 0;
    int wr_n = 0, done_n = 0, both_hi = 0, wr_in_wait = 0, rx_n = 0;
    logic [AW-1:0] wr_addr [32];
    logic [7:0] wr_data [32];
    int wr_cyc [32];
    logic [7:0] rx [128];
    logic rnd_en = 1'b0;
    int w0, d0, r0, t_fall, bad;
    logic [7:0] exp_b [4];

    ioctl_host_xfer #(.ADDR_W(AW), .WR_GAP(3), .RD_LAT(2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_upload(cmd_upload),
        .cmd_index(cmd_index), .cmd_len(cmd_len), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;
    assign src_data = src_mem[3'(src_idx - src_base)];

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (src_ready) src_idx <= src_idx + 1;
        if (snk_valid && snk_ready) begin
            rx[rx_n[6:0]] <= snk_data;
            rx_n <= rx_n + 1;
        end
        ioctl_din <= ioctl_addr[7:0] ^ 8'h3C;
    end

    always @(negedge clk_sys) begin
        if (ioctl_wr && wr_n < 32) begin
            wr_addr[wr_n] = ioctl_addr;
            wr_data[wr_n] = ioctl_dout;
            wr_cyc[wr_n] = cyc;
        end
        if (ioctl_wr) wr_n++;
        if (done) done_n++;
        if (ioctl_download && ioctl_upload) both_hi++;
        if (ioctl_wr && ioctl_wait) wr_in_wait++;
        snk_ready = rnd_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic up, input logic [7:0] idx, input logic [AW-1:0] len);
        @(negedge clk_sys);
        cmd_start = 1'b1;
        cmd_upload = up;
        cmd_index = idx;
        cmd_len = len;
        @(negedge clk_sys);
        cmd_start = 1'b0;
    endtask

    task automatic load_src(input logic [7:0] b0, b1, b2, b3);
        src_mem[0] = b0; src_mem[1] = b1; src_mem[2] = b2; src_mem[3] = b3;
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        src_base = src_idx;
        w0 = wr_n;
        d0 = done_n;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int k = 0; k < limit && done !== 1'b1; k++) @(negedge clk_sys);
        chk(tag, done, 1);
    endtask

    task automatic chk_writes(input string tag, input int n);
        chk({tag, "_count"}, wr_n - w0, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, wr_addr[w0 + i], i);
            chk({tag, "_data"}, wr_data[w0 + i], exp_b[i]);
        end
        chk({tag, "_done_once"}, done_n - d0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_busy", busy, 0);
        chk("rst_windows", {ioctl_download, ioctl_upload}, 0);
        chk("rst_wr_done", {ioctl_wr, done, snk_valid}, 0);
        chk("rst_addr", ioctl_addr, 0);
        reset_n = 1'b1;

        load_src(8'hA5, 8'h5A, 8'h00, 8'hFF);
        src_valid = 1'b1;
        start(1'b0, IDX_ROM, 4);
        chk("t1_busy", busy, 1);
        chk("t1_dl_early", ioctl_download, 0);
        @(negedge clk_sys);
        chk("t1_dl_open", ioctl_download, 1);
        wait_done("t1_done", 100);
        chk("t1_dl_closed", ioctl_download, 0);
        chk("t1_busy_on_done", busy, 1);
        chk("t1_last_addr", ioctl_addr, 3);
        @(negedge clk_sys);
        chk("t1_idle", busy, 0);
        chk_writes("t1", 4);
        for (int i = 1; i < 4; i++) chk("t1_spacing", wr_cyc[w0 + i] - wr_cyc[w0 + i - 1], 4);

        load_src(8'h11, 8'h22, 8'h33, 8'h44);
        start(1'b0, IDX_ROM, 4);
        for (int k = 0; k < 50 && wr_n <= w0; k++) @(negedge clk_sys);
        @(negedge clk_sys);
        ioctl_wait = 1'b1;
        repeat (10) @(negedge clk_sys);
        ioctl_wait = 1'b0;
        t_fall = cyc;
        wait_done("t2_done", 200);
        @(negedge clk_sys);
        chk_writes("t2", 4);
        chk("t2_delayed", wr_cyc[w0 + 1] > t_fall, 1);

        r0 = rx_n;
        d0 = done_n;
        rnd_en = 1'b1;
        start(1'b1, IDX_NVRAM, 64);
        chk("t3_ul_early", ioctl_upload, 0);
        @(negedge clk_sys);
        chk("t3_ul_open", ioctl_upload, 1);
        chk("t3_dl_low", ioctl_download, 0);
        chk("t3_index", ioctl_index, 4);
        wait_done("t3_done", 3000);
        rnd_en = 1'b0;
        chk("t3_ul_closed", ioctl_upload, 0);
        chk("t3_last_addr", ioctl_addr, 63);
        @(negedge clk_sys);
        chk("t3_count", rx_n - r0, 64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (rx[(r0 + i) & 127] !== (8'(i) ^ 8'h3C)) bad++;
        chk("t3_order", bad, 0);
        chk("t3_first", rx[r0 & 127], 8'h3C);
        chk("t3_done_once", done_n - d0, 1);

        w0 = wr_n;
        d0 = done_n;
        start(1'b0, 8'h12, 0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        chk("t4_windows", {ioctl_download, ioctl_upload}, 0);
        chk("t4_addr", ioctl_addr, 0);
        @(negedge clk_sys);
        chk("t4_idle", {busy, done}, 0);
        chk("t4_no_wr", wr_n - w0, 0);
        chk("t4_done_once", done_n - d0, 1);

        load_src(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        start(1'b0, 8'h09, 4);
        for (int k = 0; k < 50 && wr_n < w0 + 2; k++) @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_windows", {ioctl_download, ioctl_upload, ioctl_wr, done}, 0);
        chk("t5_addr", ioctl_addr, 0);
        chk("t5_index_dout", {ioctl_index, ioctl_dout}, 0);
        repeat (3) @(negedge clk_sys);
        chk("t5_no_done", done_n - d0, 0);
        reset_n = 1'b1;
        load_src(8'hC3, 8'h3C, 8'h00, 8'h00);
        start(1'b0, 8'h01, 2);
        wait_done("t5_redo_done", 100);
        chk("t5_redo_index", ioctl_index, 1);
        @(negedge clk_sys);
        chk_writes("t5_redo", 2);

        load_src(8'h61, 8'h62, 8'h00, 8'h00);
        start(1'b0, IDX_ROM, 2);
        cmd_start = 1'b1;
        cmd_upload = 1'b1;
        cmd_index = 8'h77;
        cmd_len = 9;
        @(negedge clk_sys);
        cmd_start = 1'b0;
        chk("t6_index_kept", ioctl_index, 0);
        chk("t6_dir_kept", {ioctl_download, ioctl_upload}, 2'b10);
        wait_done("t6_done", 100);
        cmd_start = 1'b1;
        cmd_index = 8'h55;
        cmd_len = 3;
        cmd_upload = 1'b0;
        @(negedge clk_sys);
        cmd_start = 1'b0;
        chk("t6_idle", busy, 0);
        @(negedge clk_sys);
        chk("t6_stay_idle", busy, 0);
        chk("t6_index_after", ioctl_index, 0);
        chk_writes("t6", 2);

        chk("never_both_windows", both_hi, 0);
        chk("no_wr_in_wait", wr_in_wait, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
